// File: rtl/pipe_bus_arbiter.sv
// Bus arbiter between the CPU pipeline (priority owner) and a single DMA requester.
// Ownership changes between CPU and DMA pass through TURN_CYCLES dead cycles with no grant.
module pipe_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned MAX_DMA_HOLD = 16,
   parameter int unsigned TURN_CYCLES  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_req,
   input  logic       dma_req,
   output logic       cpu_grant,
   output logic       dma_grant,
   output logic       pipe_stall,
   output logic [1:0] bus_owner,
   output logic       dma_forced
);

   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned HoldW   = $clog2(MAX_DMA_HOLD + 1);
   localparam int unsigned TurnW   = $clog2(TURN_CYCLES + 1);

   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
   localparam logic [HoldW-1:0]   HoldLast  = HoldW'(MAX_DMA_HOLD - 1);
   localparam logic [TurnW-1:0]   TurnLast  = TurnW'(TURN_CYCLES - 1);

   // Encoding doubles as the bus_owner code.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCpu  = 2'd1,
      StTurn = 2'd2,
      StDma  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic               target_dma_q, target_dma_d;
   logic [StarveW-1:0] starve_q, starve_d;
   logic [HoldW-1:0]   hold_q, hold_d;
   logic [TurnW-1:0]   turn_q, turn_d;
   logic               dma_forced_q, dma_forced_d;

   always_comb begin
      state_d      = state_q;
      target_dma_d = target_dma_q;
      dma_forced_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cpu_req) begin
               state_d = StCpu;
            end else if (dma_req) begin
               state_d = StDma;
            end
         end
         StCpu: begin
            if (!cpu_req) begin
               if (dma_req) begin
                  state_d      = StTurn;
                  target_dma_d = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end else if (starve_q == StarveMax) begin
               // DMA has waited long enough: pre-empt the CPU.
               state_d      = StTurn;
               target_dma_d = 1'b1;
            end
         end
         StTurn: begin
            if (turn_q == TurnLast) begin
               if (target_dma_q && dma_req) begin
                  state_d = StDma;
               end else if (cpu_req) begin
                  state_d = StCpu;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StDma: begin
            if (!dma_req || (hold_q == HoldLast)) begin
               dma_forced_d = dma_req;
               if (cpu_req) begin
                  state_d      = StTurn;
                  target_dma_d = 1'b0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      turn_d = '0;
      if ((state_q == StTurn) && (turn_q != TurnLast)) begin
         turn_d = turn_q + TurnW'(1);
      end

      hold_d = '0;
      if ((state_q == StDma) && (state_d == StDma)) begin
         hold_d = hold_q + HoldW'(1);
      end

      // Saturating wait counter; cleared once DMA owns the bus or stops asking.
      starve_d = starve_q;
      if (!dma_req || (state_q == StDma) || (state_d == StDma)) begin
         starve_d = '0;
      end else if (starve_q != StarveMax) begin
         starve_d = starve_q + StarveW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         target_dma_q <= 1'b0;
         starve_q     <= '0;
         hold_q       <= '0;
         turn_q       <= '0;
         dma_forced_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         target_dma_q <= target_dma_d;
         starve_q     <= starve_d;
         hold_q       <= hold_d;
         turn_q       <= turn_d;
         dma_forced_q <= dma_forced_d;
      end
   end

   assign cpu_grant  = (state_q == StCpu);
   assign dma_grant  = (state_q == StDma);
   assign bus_owner  = state_q;
   assign dma_forced = dma_forced_q;
   assign pipe_stall = cpu_req & ~cpu_grant;

endmodule

// File: tb/tb_pipe_bus_arbiter.sv
// Scoreboard bench for pipe_bus_arbiter: two builds (TURN_CYCLES 1 and 3) share stimulus and are
// compared each cycle against a behavioural ownership model.
module tb_pipe_bus_arbiter;

   localparam int SL = 8;
   localparam int MH = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cpu_req, dma_req;
   logic       cg1, dg1, st1, fo1, cg3, dg3, st3, fo3;
   logic [1:0] ow1, ow3;

   always #5 clk = ~clk;

   pipe_bus_arbiter #(.STARVE_LIMIT(SL), .MAX_DMA_HOLD(MH), .TURN_CYCLES(1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .dma_req    (dma_req),
      .cpu_grant  (cg1),
      .dma_grant  (dg1),
      .pipe_stall (st1),
      .bus_owner  (ow1),
      .dma_forced (fo1)
   );

   pipe_bus_arbiter #(.STARVE_LIMIT(SL), .MAX_DMA_HOLD(MH), .TURN_CYCLES(3)) u_dut3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .dma_req    (dma_req),
      .cpu_grant  (cg3),
      .dma_grant  (dg3),
      .pipe_stall (st3),
      .bus_owner  (ow3),
      .dma_forced (fo3)
   );

   // owner: 0 nobody, 1 CPU, 2 handover gap, 3 DMA
   typedef struct {
      int owner;
      int gap_left;
      bit gap_to_dma;
      int tenure;
      int wait_age;
      bit forced;
   } mdl_t;

   typedef struct packed {
      logic       cg;
      logic       dg;
      logic [1:0] ow;
      logic       fo;
      logic       st;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
   } exp_t;

   typedef struct {
      int n;
      bit c;
      bit d;
   } ph_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   mdl_t m1, m3;
   ph_t  ph[15];

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.owner      = 0;
      r.gap_left   = 0;
      r.gap_to_dma = 1'b0;
      r.tenure     = 0;
      r.wait_age   = 0;
      r.forced     = 1'b0;
      return r;
   endfunction

   function automatic mdl_t mdl_step(mdl_t s, bit c, bit d, int tc);
      mdl_t n = s;
      n.forced = 1'b0;
      case (s.owner)
         0: n.owner = c ? 1 : (d ? 3 : 0);
         1: begin
            if (!c && !d) begin
               n.owner = 0;
            end else if (!c || s.wait_age == SL) begin
               n.owner = 2; n.gap_left = tc; n.gap_to_dma = 1'b1;
            end
         end
         2: begin
            if (s.gap_left > 1) n.gap_left = s.gap_left - 1;
            else if (s.gap_to_dma && d) n.owner = 3;
            else n.owner = c ? 1 : 0;
         end
         default: begin
            if (!d || s.tenure + 1 == MH) begin
               n.forced = d;
               if (c) begin
                  n.owner = 2; n.gap_left = tc; n.gap_to_dma = 1'b0;
               end else begin
                  n.owner = 0;
               end
            end
         end
      endcase
      n.tenure = (s.owner == 3 && n.owner == 3) ? s.tenure + 1 : 0;
      if (!d || s.owner == 3 || n.owner == 3) n.wait_age = 0;
      else n.wait_age = (s.wait_age < SL) ? s.wait_age + 1 : SL;
      return n;
   endfunction

   function automatic obs_t mdl_obs(mdl_t s, bit c);
      obs_t o;
      o.cg = (s.owner == 1);
      o.dg = (s.owner == 3);
      o.ow = 2'(s.owner);
      o.fo = s.forced;
      o.st = c && (s.owner != 1);
      return o;
   endfunction

   task automatic push_exp(input bit c);
      exp_t e;
      e.a = mdl_obs(m1, c);
      e.b = mdl_obs(m3, c);
      sb_q.push_back(e);
   endtask

   task automatic drive(input bit c, input bit d);
      @(posedge clk);
      #1;
      cpu_req = c;
      dma_req = d;
      push_exp(c);
      m1 = mdl_step(m1, c, d, 1);
      m3 = mdl_step(m3, c, d, 3);
   endtask

   // Reset asserted between edges so the grant drop is seen before any clock edge.
   task automatic do_reset(input bit c);
      @(posedge clk);
      #2;
      rst_n   = 1'b0;
      cpu_req = c;
      dma_req = 1'b0;
      m1 = mdl_reset();
      m3 = mdl_reset();
      push_exp(c);
      @(posedge clk);
      #1;
      push_exp(c);
      #1;
      rst_n = 1'b1;
      m1 = mdl_step(m1, c, 1'b0, 1);
      m3 = mdl_step(m3, c, 1'b0, 3);
   endtask

   task automatic cmp(input string nm, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp("t1_cpu_grant", {1'b0, cg1}, {1'b0, e.a.cg});
            cmp("t1_dma_grant", {1'b0, dg1}, {1'b0, e.a.dg});
            cmp("t1_bus_owner", ow1, e.a.ow);
            cmp("t1_dma_forced", {1'b0, fo1}, {1'b0, e.a.fo});
            cmp("t1_pipe_stall", {1'b0, st1}, {1'b0, e.a.st});
            cmp("t1_grant_excl", {1'b0, cg1 & dg1}, 2'd0);
            cmp("t3_cpu_grant", {1'b0, cg3}, {1'b0, e.b.cg});
            cmp("t3_dma_grant", {1'b0, dg3}, {1'b0, e.b.dg});
            cmp("t3_bus_owner", ow3, e.b.ow);
            cmp("t3_dma_forced", {1'b0, fo3}, {1'b0, e.b.fo});
            cmp("t3_pipe_stall", {1'b0, st3}, {1'b0, e.b.st});
            cmp("t3_grant_excl", {1'b0, cg3 & dg3}, 2'd0);
         end
      end
   end

   initial begin : stimulus
      bit c, d;
      rst_n   = 1'b0;
      cpu_req = 1'b0;
      dma_req = 1'b0;
      m1 = mdl_reset();
      m3 = mdl_reset();
      ph = '{
         '{4, 1'b1, 1'b0}, '{3, 1'b0, 1'b0}, '{14, 1'b1, 1'b1}, '{3, 1'b1, 1'b0},
         '{3, 1'b0, 1'b0}, '{5, 1'b0, 1'b1}, '{4, 1'b0, 1'b0}, '{2, 1'b0, 1'b1},
         '{30, 1'b1, 1'b1}, '{4, 1'b1, 1'b0}, '{3, 1'b0, 1'b0}, '{20, 1'b0, 1'b1},
         '{3, 1'b0, 1'b0}, '{4, 1'b0, 1'b1}, '{1, 1'b0, 1'b1}
      };

      do_reset(1'b1);
      for (int i = 0; i < 15; i++) begin
         for (int k = 0; k < ph[i].n; k++) drive(ph[i].c, ph[i].d);
      end
      // Both builds are mid-DMA tenure here.
      do_reset(1'b1);
      for (int k = 0; k < 4; k++) drive(1'b1, 1'b0);

      c = 1'b0;
      d = 1'b0;
      for (int k = 0; k < 10000; k++) begin
         if ($urandom_range(0, 5) == 0) c = ~c;
         if ($urandom_range(0, 11) == 0) d = ~d;
         drive(c, d);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_bus_arbiter.md
Name: pipe_bus_arbiter

Overview:
- Arbitrates the main data bus between the CPU pipeline and one external DMA requester.
- The CPU side is driven by the stage-2 bus-request control line.
- CPU has priority. A starvation counter guarantees DMA access, and a hold limit bounds DMA tenure.
- Inserts turnaround cycles on every ownership change and raises a stall to freeze the pipeline while the CPU is not granted.

Parameters:
- STARVE_LIMIT, 8: cycles a blocked dma_req waits before it pre-empts an active CPU tenure (1..255).
- MAX_DMA_HOLD, 16: maximum consecutive DMA-granted cycles before forced release (1..255).
- TURN_CYCLES, 1: dead cycles with no grant on every CPU<->DMA handover (1..15).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_req  input  1  pipeline bus request (stage-2 BusRequest control bit).
- dma_req  input  1  DMA requester wants the bus; level, held until done.
- cpu_grant  output  1  registered; CPU owns the bus this cycle.
- dma_grant  output  1  registered; DMA owns the bus this cycle.
- pipe_stall  output  1  combinational; cpu_req & ~cpu_grant, freezes pipeline latches.
- bus_owner  output  2  registered; 0 idle, 1 CPU, 2 turnaround, 3 DMA (mirrors state).
- dma_forced  output  1  registered one-cycle pulse when DMA is cut off by MAX_DMA_HOLD.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all grants 0; bus_owner=0; dma_forced=0.
  - All counters 0.
  - Reset mid-tenure drops the grant immediately, asynchronously.
- State machine (IDLE, CPU, TURN, DMA):
  - Grants are decoded from registered state, so latency from request to grant is 1 cycle.
- IDLE:
  - cpu_req=1 -> CPU (CPU wins a simultaneous request).
  - Else dma_req=1 -> DMA.
  - Else stay in IDLE.
  - IDLE->either owner is direct, with no turnaround.
- CPU:
  - cpu_req=0 with dma_req=1 -> TURN (target DMA).
  - cpu_req=0 with dma_req=0 -> IDLE.
  - cpu_req=1 with starve_cnt==STARVE_LIMIT -> TURN (target DMA), which pre-empts the CPU.
  - Otherwise stay in CPU.
- TURN:
  - turn_cnt counts 0..TURN_CYCLES-1; no grant is asserted.
  - A registered target bit selects the next owner.
  - On the last cycle, re-evaluate:
    - target DMA and dma_req still 1 -> DMA.
    - target DMA and dma_req dropped -> CPU if cpu_req, else IDLE.
    - target CPU -> CPU if cpu_req, else IDLE.
- DMA:
  - hold_cnt increments every cycle in DMA.
  - dma_req=0 -> TURN (target CPU) if cpu_req, else IDLE.
  - hold_cnt==MAX_DMA_HOLD-1 with dma_req=1 -> pulse dma_forced next cycle, then TURN (target CPU) if cpu_req, else IDLE.
  - If forced release lands in IDLE while dma_req is still 1, DMA is re-granted next cycle. This is legal.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on cycles with dma_req=1 and state!=DMA.
  - Clears when dma_req=0 or on DMA entry.
- Counters are sized $clog2(limit+1); no wrap is permitted.
- Invariant: cpu_grant & dma_grant is never 1; a bench assertion checks this.
- pipe_stall is asserted in IDLE on the first request cycle, and throughout TURN and DMA while cpu_req=1.
- cpu_req dropping inside TURN does not shorten TURN.

Test Plan:
- Reset then cpu_req=1 at cycle 0 -> cycle 0: pipe_stall=1. Cycle 1: cpu_grant=1, bus_owner=1, pipe_stall=0.
- cpu_req and dma_req both rise together from IDLE -> cpu_grant next cycle. After 8 blocked cycles (STARVE_LIMIT=8), 1 TURN cycle with both grants 0, then dma_grant=1 and pipe_stall=1.
- dma_req held high for 30 cycles with cpu_req=1 -> dma_grant high exactly 16 cycles, then dma_forced pulses once, TURN for 1 cycle, then cpu_grant=1.
- dma_req alone, held 5 cycles then dropped -> dma_grant is high for the 5 cycles that follow the request with 1-cycle latency; then IDLE, with no turnaround and no dma_forced.
- rst_n pulsed low mid-DMA tenure -> dma_grant falls in the same cycle (async), bus_owner=0; on release, cpu_req=1 gets cpu_grant after 1 cycle.
- TURN_CYCLES=3 build, CPU->DMA handover -> exactly 3 cycles with both grants 0. Random-stimulus run of 10k cycles -> no cycle with both grants high.
